// File: rtl/sysid_multi_rom.sv
// sysid_multi_rom: AXI4-Lite system-ID register block with windowed ROM
// reads and a background checksum engine over one selected ROM.
module sysid_multi_rom #(
    parameter int NUM_ROMS      = 2,
    parameter int ROM_WIDTH     = 32,
    parameter int ROM_ADDR_BITS = 9,
    parameter int ROM_LATENCY   = 1
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          s_axi_awvalid,
    input  logic [15:0]                   s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    output logic                          s_axi_awready,
    input  logic                          s_axi_wvalid,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    output logic                          s_axi_wready,
    output logic                          s_axi_bvalid,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_bready,
    input  logic                          s_axi_arvalid,
    input  logic [15:0]                   s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    output logic                          s_axi_arready,
    output logic                          s_axi_rvalid,
    output logic [1:0]                    s_axi_rresp,
    output logic [31:0]                   s_axi_rdata,
    input  logic                          s_axi_rready,
    input  logic [NUM_ROMS*ROM_WIDTH-1:0] rom_data,
    output logic [ROM_ADDR_BITS-1:0]      rom_addr
);

    localparam int AW = ROM_ADDR_BITS;
    localparam logic [1:0] LAT_M1 = 2'(ROM_LATENCY - 1);
    localparam logic [1:0] LAT = 2'(ROM_LATENCY);
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {CK_IDLE, CK_ADDR, CK_WAIT, CK_ACC} ck_state_t;

    function automatic logic [31:0] rom_word(
        input logic [1:0]                    idx,
        input logic [NUM_ROMS*ROM_WIDTH-1:0] bus
    );
        logic [31:0] v;
        v = '0;
        for (int n = 0; n < NUM_ROMS; n++) begin
            if (idx == 2'(n)) v = 32'(bus[n*ROM_WIDTH +: ROM_WIDTH]);
        end
        return v;
    endfunction

    logic            awready_q, awready_d;
    logic            bvalid_q, bvalid_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [31:0]     scratch_q, scratch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [31:0]     sum_q, sum_d;
    logic [1:0]      sel_q, sel_d;
    ck_state_t       ck_state_q, ck_state_d;
    logic [AW-1:0]   ck_addr_q, ck_addr_d;
    logic [1:0]      ck_cnt_q, ck_cnt_d;
    rd_state_t       rd_state_q, rd_state_d;
    logic [1:0]      rd_cnt_q, rd_cnt_d;
    logic            rd_go_q, rd_go_d;
    logic [AW-1:0]   rd_off_q, rd_off_d;
    logic [1:0]      rd_rom_q, rd_rom_d;

    logic [AW+1:0]   aw_word, ar_word;
    logic [1:0]      aw_region, ar_region;
    logic [AW-1:0]   aw_off, ar_off;
    logic            ar_is_rom, wr_fire, wr_reg, ctrl_start;
    logic [31:0]     reg_rdata;
    logic            unused_bits;

    assign aw_word   = s_axi_awaddr[AW+3:2];
    assign ar_word   = s_axi_araddr[AW+3:2];
    assign aw_region = aw_word[AW+1:AW];
    assign ar_region = ar_word[AW+1:AW];
    assign aw_off    = aw_word[AW-1:0];
    assign ar_off    = ar_word[AW-1:0];
    assign ar_is_rom = (ar_region != 2'd0) && (32'(ar_region) <= 32'(NUM_ROMS));
    assign wr_fire   = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign wr_reg    = wr_fire && (aw_region == 2'd0);
    assign ctrl_start = wr_reg && (aw_off == AW'(6)) && s_axi_wdata[8];

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                           s_axi_awaddr, s_axi_araddr};

    always_comb begin
        reg_rdata = '0;
        case (ar_off)
            AW'(0):  reg_rdata = 32'h0002_0061;
            AW'(2):  reg_rdata = scratch_q;
            AW'(3):  reg_rdata = 32'h5359_4944;
            AW'(4):  reg_rdata = 32'(NUM_ROMS);
            AW'(5):  reg_rdata = 32'(ROM_ADDR_BITS);
            AW'(7):  reg_rdata = {29'd0, err_q, done_q, busy_q};
            AW'(8):  reg_rdata = sum_q;
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        awready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rom_addr_d = rom_addr_q;
        scratch_d  = scratch_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        sum_d      = sum_q;
        sel_d      = sel_q;
        ck_state_d = ck_state_q;
        ck_addr_d  = ck_addr_q;
        ck_cnt_d   = ck_cnt_q;
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_go_d    = rd_go_q;
        rd_off_d   = rd_off_q;
        rd_rom_d   = rd_rom_q;

        if (!awready_q && !bvalid_q && s_axi_awvalid && s_axi_wvalid)
            awready_d = 1'b1;
        if (wr_fire)
            bvalid_d = 1'b1;
        else if (bvalid_q && s_axi_bready)
            bvalid_d = 1'b0;
        if (wr_reg && aw_off == AW'(2))
            scratch_d = s_axi_wdata;

        // The read FSM only touches rom_addr while the engine is idle.
        unique case (rd_state_q)
            RD_IDLE: begin
                if (arready_q && s_axi_arvalid) begin
                    if (ar_is_rom) begin
                        rd_rom_d   = ar_region - 2'd1;
                        rd_off_d   = ar_off;
                        rd_cnt_d   = 2'd0;
                        rd_state_d = RD_WAIT;
                        rd_go_d    = !busy_q;
                        if (!busy_q) rom_addr_d = ar_off;
                    end else begin
                        rdata_d    = (ar_region == 2'd0) ? reg_rdata : 32'd0;
                        rvalid_d   = 1'b1;
                        rd_state_d = RD_RESP;
                    end
                end else if (s_axi_arvalid && !arready_q) begin
                    arready_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (busy_q) begin
                    rd_go_d = 1'b0;
                end else if (!rd_go_q) begin
                    rom_addr_d = rd_off_q;
                    rd_go_d    = 1'b1;
                    rd_cnt_d   = 2'd0;
                end else if (rd_cnt_q == LAT) begin
                    rdata_d    = rom_word(rd_rom_q, rom_data);
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        unique case (ck_state_q)
            CK_IDLE: begin
                if (ctrl_start) begin
                    done_d = 1'b0;
                    if (32'(s_axi_wdata[1:0]) < 32'(NUM_ROMS)) begin
                        err_d      = 1'b0;
                        sum_d      = '0;
                        busy_d     = 1'b1;
                        sel_d      = s_axi_wdata[1:0];
                        ck_addr_d  = '0;
                        ck_state_d = CK_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CK_ADDR: begin
                rom_addr_d = ck_addr_q;
                ck_cnt_d   = 2'd0;
                ck_state_d = CK_WAIT;
            end
            CK_WAIT: begin
                if (ck_cnt_q == LAT_M1) ck_state_d = CK_ACC;
                else ck_cnt_d = ck_cnt_q + 2'd1;
            end
            CK_ACC: begin
                sum_d = sum_q + rom_word(sel_q, rom_data);
                if (ck_addr_q == LAST) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    ck_addr_d  = '0;
                    ck_state_d = CK_IDLE;
                end else begin
                    ck_addr_d  = ck_addr_q + AW'(1);
                    ck_state_d = CK_ADDR;
                end
            end
            default: ck_state_d = CK_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rom_addr_q <= '0;
            scratch_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sum_q      <= '0;
            sel_q      <= '0;
            ck_state_q <= CK_IDLE;
            ck_addr_q  <= '0;
            ck_cnt_q   <= '0;
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_go_q    <= 1'b0;
            rd_off_q   <= '0;
            rd_rom_q   <= '0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rom_addr_q <= rom_addr_d;
            scratch_q  <= scratch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sum_q      <= sum_d;
            sel_q      <= sel_d;
            ck_state_q <= ck_state_d;
            ck_addr_q  <= ck_addr_d;
            ck_cnt_q   <= ck_cnt_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_go_q    <= rd_go_d;
            rd_off_q   <= rd_off_d;
            rd_rom_q   <= rd_rom_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = rdata_q;
    assign rom_addr      = rom_addr_q;

endmodule

// File: doc/sysid_multi_rom.md
SYSID_MULTI_ROM -- requirements
Module: sysid_multi_rom

Interface
REQ-001 SHALL have parameter NUM_ROMS, default 2, number of ROM regions (1..3).
REQ-002 SHALL have parameter ROM_WIDTH, default 32, ROM word width (1..32), zero-extended to 32 on read.
REQ-003 SHALL have parameter ROM_ADDR_BITS, default 9, word-address bits per ROM (4..12).
REQ-004 SHALL have parameter ROM_LATENCY, default 1, ROM read latency in clocks (1..3).
REQ-005 SHALL have ports: s_axi_aclk in 1 clock; s_axi_aresetn in 1 reset, asynchronous, active-low.
REQ-006 SHALL have AXI4-Lite slave ports s_axi_aw{valid,addr[15:0],prot[2:0],ready}, s_axi_w{valid,data[31:0],strb[3:0],ready}, s_axi_b{valid,resp[1:0],ready}, s_axi_ar{valid,addr[15:0],prot[2:0],ready}, s_axi_r{valid,resp[1:0],data[31:0],ready}, directions per AXI4-Lite slave.
REQ-007 SHALL have rom_data in NUM_ROMS*ROM_WIDTH, ROM n data on bits [n*ROM_WIDTH +: ROM_WIDTH].
REQ-008 SHALL have rom_addr out ROM_ADDR_BITS, shared word address to all ROMs.

Function
REQ-009 SHALL decode word address A = axaddr[ROM_ADDR_BITS+3:2]; region R = A[ROM_ADDR_BITS+1:ROM_ADDR_BITS], offset = A[ROM_ADDR_BITS-1:0]; other address bits ignored.
REQ-010 SHALL map region 0 registers: 0x00 version 0x00020061 RO; 0x01 0 RO; 0x02 scratch RW; 0x03 magic 0x53594944 RO; 0x04 NUM_ROMS RO; 0x05 ROM_ADDR_BITS RO; 0x06 ctrl RW (bits[1:0] sel, bit8 start, self-clearing, reads 0); 0x07 status RO (bit0 busy, bit1 done, bit2 err); 0x08 checksum RO; others read 0.
REQ-011 SHALL map region R (1..NUM_ROMS) to ROM R-1 at offset; regions > NUM_ROMS read 0.
REQ-012 SHALL accept a write only when awvalid and wvalid both high and bvalid low; awready=wready pulse 1 cycle; bvalid next cycle, held until bready; bresp=0.
REQ-013 SHALL apply writes to full 32 bits ignoring wstrb; writes to RO/unmapped addresses are dropped but still acknowledged.
REQ-014 SHALL read via FSM IDLE->WAIT->RESP: arready pulses 1 cycle in IDLE on arvalid; register reads go to RESP next cycle; ROM reads drive rom_addr then wait ROM_LATENCY cycles before capture.
REQ-015 SHALL hold rvalid with stable rdata until rready, rresp=0, then return to IDLE; next arready no earlier than cycle after handshake.
REQ-016 SHALL, while checksum engine busy, hold a ROM-region read in WAIT (engine owns rom_addr) until engine idle, then start its ROM_LATENCY count; register reads unaffected.
REQ-017 SHALL start checksum on ctrl write with bit8=1 when not busy and sel < NUM_ROMS: clear done/err, checksum:=0, busy:=1.
REQ-018 SHALL set err, not start, if sel >= NUM_ROMS; start while busy SHALL be ignored (no status change).
REQ-019 SHALL sum every word 0..2^ROM_ADDR_BITS-1 of ROM sel, zero-extended, modulo 2^32; engine FSM IDLE->ADDR->WAIT(ROM_LATENCY cycles)->ACC per word, ROM_LATENCY+2 cycles/word.
REQ-020 SHALL, on ACC of last word, clear busy and set done in the same cycle; address counter wraps to 0.
REQ-021 SHALL drive rom_addr from engine when busy, else from read FSM, else hold last value.

Reset
REQ-022 SHALL on s_axi_aresetn low asynchronously clear: all ready/valid outputs 0, rdata 0, resp 0, rom_addr 0, scratch 0, busy/done/err 0, checksum 0, FSMs IDLE.
REQ-023 SHALL abort an in-progress checksum or AXI transaction on reset without a response.

Verification
REQ-024 SHALL cover: read 0x00C, 0x010 -> rdata 0x53594944, 0x00000002; write 0x008=0xA5A55A5A then read -> 0xA5A55A5A, bvalid held over 3 cycles of bready low.
REQ-025 SHALL cover: ROM1 word k=k, read byte address (2<<ROM_ADDR_BITS+5)<<2 with ROM_LATENCY=3 -> rdata 5, rvalid exactly 5 cycles after arready.
REQ-026 SHALL cover: ROM0 word k=k, ROM_ADDR_BITS=4, write ctrl=0x100 -> busy 1, after 16*(ROM_LATENCY+2) cycles status 0x2, checksum 120.
REQ-027 SHALL cover: ctrl sel=3 with NUM_ROMS=2 -> status 0x4; start during busy -> checksum unchanged; ROM read during busy -> rvalid only after done.
REQ-028 SHALL cover: reset asserted mid-checksum and mid-read -> all outputs 0 immediately, status 0 after release, next read completes normally.
